// File: rtl/daq_readout_sched.sv
// Readout scheduler: counts queued L1A events and launches one frame at a time (START, WAIT with watchdog, GAP).
// l1a_acc -> rd_start two cycles later when idle; trig_stop holds off new frames, l1a_busy throttles the L1A source.
module daq_readout_sched #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned GAP     = 2
) (
    input  logic        clk,
    input  logic        hard_rst,
    input  logic        l1a_acc,
    input  logic        rd_done,
    input  logic        trig_stop,
    input  logic        cfg_req,
    input  logic [3:0]  busy_thresh,
    output logic        rd_start,
    output logic        config_report,
    output logic [3:0]  pending,
    output logic        l1a_busy,
    output logic [11:0] readout_count,
    output logic        overflow,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT);
    localparam logic [1:0] GAP_LAST = 2'(GAP - 1);

    state_t     state;
    logic [9:0] wdog;
    logic [1:0] gap_cnt;
    logic       cfg_pend;
    logic       in_start;

    assign in_start = (state == S_START);
    assign l1a_busy = (busy_thresh != 4'd0) && (pending >= busy_thresh);

    always_ff @(posedge clk) begin
        if (!hard_rst) begin
            state         <= S_IDLE;
            wdog          <= '0;
            gap_cnt       <= '0;
            cfg_pend      <= 1'b1;
            rd_start      <= 1'b0;
            config_report <= 1'b0;
            pending       <= '0;
            readout_count <= '0;
            overflow      <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            rd_start <= 1'b0;

            // The START pop and a new arrival cancel, so a full queue never overflows while popping.
            if (l1a_acc && !in_start) begin
                if (pending == 4'd15) begin
                    overflow <= 1'b1;
                end else begin
                    pending <= pending + 4'd1;
                end
            end else if (!l1a_acc && in_start) begin
                pending <= pending - 4'd1;
            end

            if (cfg_req) begin
                cfg_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (pending != 4'd0 && !trig_stop) begin
                        state         <= S_START;
                        rd_start      <= 1'b1;
                        config_report <= cfg_pend;
                        // A request arriving now belongs to the following frame.
                        cfg_pend      <= cfg_req;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                    wdog  <= '0;
                end
                S_WAIT: begin
                    if (rd_done) begin
                        readout_count <= readout_count + 12'd1;
                        state         <= S_GAP;
                        gap_cnt       <= '0;
                    end else if (wdog == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_GAP;
                        gap_cnt     <= '0;
                    end else begin
                        wdog <= wdog + 10'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state         <= S_IDLE;
                        config_report <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_daq_readout_sched.sv
// Bench for daq_readout_sched: timestamp-based reference model feeds scoreboard queues, negedge monitor compares.
module tb_daq_readout_sched;

    localparam int TMO = 30;
    localparam int GP  = 3;

    logic        clk = 1'b0;
    logic        hard_rst, l1a_acc, rd_done, trig_stop, cfg_req;
    logic [3:0]  busy_thresh;
    logic        rd_start, config_report, l1a_busy, overflow, timeout_err;
    logic [3:0]  pending;
    logic [11:0] readout_count;

    always #5 clk = ~clk;

    daq_readout_sched #(.TIMEOUT(TMO), .GAP(GP)) dut (
        .clk           (clk),
        .hard_rst      (hard_rst),
        .l1a_acc       (l1a_acc),
        .rd_done       (rd_done),
        .trig_stop     (trig_stop),
        .cfg_req       (cfg_req),
        .busy_thresh   (busy_thresh),
        .rd_start      (rd_start),
        .config_report (config_report),
        .pending       (pending),
        .l1a_busy      (l1a_busy),
        .readout_count (readout_count),
        .overflow      (overflow),
        .timeout_err   (timeout_err)
    );

    typedef struct {
        bit rs;
        bit crep;
        int pend;
        int cnt;
        bit ovf;
        bit terr;
    } snap_t;

    typedef struct {
        int cyc;
        bit crep;
    } frame_t;

    snap_t  stat_q[$];
    frame_t frame_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a frame is described by its START cycle and its completion cycle.
    int m_pend, m_cnt, m_fstart, m_fdone;
    bit m_cfg, m_crep, m_ovf, m_terr;

    always @(posedge clk) begin : model
        bit idle;
        bit in_start;
        if (!hard_rst) begin
            m_pend = 0; m_cnt = 0; m_fstart = -1; m_fdone = -1;
            m_cfg = 1; m_crep = 0; m_ovf = 0; m_terr = 0;
        end else begin
            idle     = (m_fstart < 0);
            in_start = (m_fstart == cyc);
            if (!idle && cyc > m_fstart && m_fdone < 0) begin
                if (rd_done) begin
                    m_fdone = cyc;
                    m_cnt = (m_cnt + 1) % 4096;
                end else if (cyc - m_fstart - 1 == TMO) begin
                    m_fdone = cyc;
                    m_terr = 1;
                end
            end else if (m_fdone >= 0 && cyc == m_fdone + GP) begin
                m_fstart = -1;
                m_fdone = -1;
                m_crep = 0;
            end
            if (idle && m_pend != 0 && !trig_stop) begin
                m_fstart = cyc + 1;
                m_crep = m_cfg;
                m_cfg = cfg_req;
                frame_q.push_back('{cyc + 1, m_crep});
            end else if (cfg_req) begin
                m_cfg = 1;
            end
            if (l1a_acc && !in_start) begin
                if (m_pend == 15) m_ovf = 1;
                else m_pend++;
            end else if (!l1a_acc && in_start) begin
                m_pend--;
            end
        end
        stat_q.push_back('{(m_fstart == cyc + 1), m_crep, m_pend, m_cnt, m_ovf, m_terr});
        cyc++;
    end

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin : monitor
        snap_t  e;
        frame_t f;
        if (stat_q.size() > 0) begin
            e = stat_q.pop_front();
            chk("rd_start", int'(rd_start), int'(e.rs));
            chk("config_report", int'(config_report), int'(e.crep));
            chk("pending", int'(pending), e.pend);
            chk("readout_count", int'(readout_count), e.cnt);
            chk("overflow", int'(overflow), int'(e.ovf));
            chk("timeout_err", int'(timeout_err), int'(e.terr));
            chk("l1a_busy", int'(l1a_busy), int'(busy_thresh != 0 && e.pend >= int'(busy_thresh)));
        end
        if (rd_start === 1'b1) begin
            if (frame_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame: unexpected rd_start at cycle %0d", cyc);
            end else begin
                f = frame_q.pop_front();
                chk("frame_cycle", cyc, f.cyc);
                chk("frame_cfg", int'(config_report), int'(f.crep));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        l1a_acc = 0;
        rd_done = 0;
        cfg_req = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_start(input int budget);
        int k = 0;
        do begin
            tick();
            k++;
        end while (rd_start !== 1'b1 && k < budget);
        total++;
        if (rd_start !== 1'b1) begin
            bad++;
            $display("FAIL wait_start: got no rd_start expected one within %0d cycles", budget);
        end
    endtask

    task automatic frame(input int delay);
        wait_start(64);
        ticks(delay);
        rd_done = 1;
        tick();
    endtask

    task automatic do_reset();
        hard_rst = 0;
        l1a_acc = 1;
        rd_done = 1;
        cfg_req = 1;
        tick();
        hard_rst = 1;
    endtask

    initial begin
        hard_rst = 0; l1a_acc = 0; rd_done = 0; trig_stop = 0; cfg_req = 0; busy_thresh = 0;
        ticks(3);
        hard_rst = 1;

        // First frame after reset carries the config report, the next does not.
        ticks(5);
        l1a_acc = 1;
        wait_start(10);
        ticks(7);
        rd_done = 1;
        ticks(8);
        l1a_acc = 1;
        frame(3);
        ticks(6);

        // cfg_req coincident with START: frame A without, frame B with the report.
        trig_stop = 1;
        repeat (2) begin l1a_acc = 1; tick(); end
        trig_stop = 0;
        wait_start(10);
        cfg_req = 1;
        ticks(2);
        rd_done = 1;
        frame(2);
        ticks(6);

        // pending = 3 with an arrival coincident with START.
        trig_stop = 1;
        repeat (3) begin l1a_acc = 1; tick(); end
        trig_stop = 0;
        wait_start(10);
        l1a_acc = 1;
        ticks(2);
        rd_done = 1;
        tick();
        repeat (3) frame(2);
        ticks(8);

        // pending = 15 with an arrival coincident with START: no overflow.
        do_reset();
        trig_stop = 1;
        repeat (15) begin l1a_acc = 1; tick(); end
        trig_stop = 0;
        wait_start(10);
        l1a_acc = 1;
        trig_stop = 1;
        ticks(2);
        rd_done = 1;
        ticks(6);

        // Saturation with throttle threshold 8 and trig_stop held.
        do_reset();
        trig_stop = 1;
        busy_thresh = 8;
        repeat (16) begin l1a_acc = 1; tick(); end
        ticks(4);
        trig_stop = 0;
        repeat (15) frame(1);
        busy_thresh = 0;
        ticks(6);

        // Completion exactly at the watchdog limit, then a real timeout, then a normal frame.
        do_reset();
        ticks(2);
        l1a_acc = 1;
        wait_start(10);
        ticks(TMO + 1);
        rd_done = 1;
        ticks(6);
        l1a_acc = 1;
        wait_start(10);
        ticks(5);
        l1a_acc = 1;
        wait_start(TMO + 20);
        ticks(4);
        rd_done = 1;
        ticks(6);

        // Reset during WAIT and during GAP abandons the frame.
        l1a_acc = 1;
        wait_start(10);
        ticks(3);
        do_reset();
        ticks(4);
        l1a_acc = 1;
        wait_start(10);
        tick();
        rd_done = 1;
        tick();
        do_reset();
        ticks(6);

        // Randomized traffic, including occasional resets.
        repeat (4000) begin
            tick();
            l1a_acc = ($urandom % 4 == 0);
            rd_done = ($urandom % 6 == 0);
            cfg_req = ($urandom % 16 == 0);
            if ($urandom % 50 == 0) trig_stop = ~trig_stop;
            if ($urandom % 200 == 0) busy_thresh = 4'($urandom);
            hard_rst = ($urandom % 500 != 0);
        end
        tick();
        hard_rst = 1;
        trig_stop = 0;
        do_reset();

        // Continuous traffic long enough to wrap readout_count.
        repeat (4200 * (GP + 3)) begin
            @(posedge clk);
            #1;
            l1a_acc = 1;
            rd_done = 1;
        end
        trig_stop = 1;
        ticks(10);

        total++;
        if (frame_q.size() != 0) begin
            bad++;
            $display("FAIL frame_q_empty: got %0d outstanding frames expected 0", frame_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
